// File: rtl/tart_spi_pkg.sv
// Shared addresses, command layout and FSM states for the TART SPI register block.
package tart_spi_pkg;

  localparam logic [6:0] ADDR_STATUS   = 7'h00;
  localparam logic [6:0] ADDR_START    = 7'h01;
  localparam logic [6:0] ADDR_DATA_MSB = 7'h02;
  localparam logic [6:0] ADDR_DATA_MID = 7'h03;
  localparam logic [6:0] ADDR_DATA_LSB = 7'h04;
  localparam logic [6:0] ADDR_DEBUG    = 7'h05;
  localparam logic [6:0] ADDR_RESET    = 7'h0F;

  localparam int CMD_WRITE_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } spi_state_t;

  function automatic logic [7:0] read_mux(input logic [6:0]  addr,
                                          input logic [7:0]  status,
                                          input logic [23:0] sample);
    case (addr)
      ADDR_STATUS:   read_mux = status;
      ADDR_DATA_MSB: read_mux = sample[23:16];
      ADDR_DATA_MID: read_mux = sample[15:8];
      ADDR_DATA_LSB: read_mux = sample[7:0];
      default:       read_mux = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus one register for edge detection.
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic fpga_clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/tart_spi_regs.sv
// SPI mode-0 slave register file for the TART receiver, oversampled in the fpga_clk domain.
// Define SPI_REGS_BURST_EN to auto-increment the read address (saturating at 0x04) after each data byte.
module tart_spi_regs
  import tart_spi_pkg::*;
(
  input  logic        fpga_clk,
  input  logic        rst_n,
  input  logic        SCK,
  input  logic        MOSI,
  input  logic        SSEL,
  output logic        MISO,
  input  logic [23:0] antenna_data,
  input  logic [7:0]  spi_status,
  output logic        spi_buffer_read_complete,
  output logic        spi_reset,
  output logic        spi_start_aq,
  output logic        spi_debug
);

  logic sck_level, sck_rise, sck_fall;
  logic ssel_level, ssel_rise, ssel_fall;
  logic mosi_meta, mosi_sync;

  spi_pin_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .fpga_clk (fpga_clk),
    .rst_n    (rst_n),
    .pin      (SCK),
    .level    (sck_level),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  // SSEL idles high, so the synchronizer resets high to avoid a phantom select after reset.
  spi_pin_sync #(.RESET_VAL(1'b1)) u_ssel_sync (
    .fpga_clk (fpga_clk),
    .rst_n    (rst_n),
    .pin      (SSEL),
    .level    (ssel_level),
    .rise     (ssel_rise),
    .fall     (ssel_fall)
  );

  logic unused_sync_outputs;
  assign unused_sync_outputs = &{1'b0, sck_level, ssel_rise};

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  spi_state_t state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out;
  logic [6:0] addr;
  logic       is_write;
  logic [7:0] rx_byte;
  logic [6:0] data_addr_next;

  assign rx_byte = {shift_in, mosi_sync};

`ifdef SPI_REGS_BURST_EN
  assign data_addr_next = (!is_write && (addr < ADDR_DATA_LSB)) ? addr + 7'd1 : addr;
`else
  assign data_addr_next = addr;
`endif

  // Shift-out byte is always loaded whole at a byte boundary so it stays stable while shifting.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= ST_IDLE;
      bit_cnt                  <= 3'd0;
      shift_in                 <= 7'd0;
      shift_out                <= 8'h00;
      addr                     <= 7'd0;
      is_write                 <= 1'b0;
      MISO                     <= 1'b0;
      spi_start_aq             <= 1'b0;
      spi_debug                <= 1'b0;
      spi_reset                <= 1'b0;
      spi_buffer_read_complete <= 1'b0;
    end else begin
      spi_reset                <= 1'b0;
      spi_buffer_read_complete <= 1'b0;
      if (ssel_level) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
      end else if (ssel_fall) begin
        state     <= ST_CMD;
        bit_cnt   <= 3'd0;
        shift_out <= spi_status;
        MISO      <= spi_status[7];
      end else if (state != ST_IDLE) begin
        if (sck_rise) begin
          shift_in <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == ST_CMD) begin
              state     <= ST_DATA;
              is_write  <= rx_byte[CMD_WRITE_BIT];
              addr      <= rx_byte[6:0];
              shift_out <= rx_byte[CMD_WRITE_BIT] ? 8'h00
                           : read_mux(rx_byte[6:0], spi_status, antenna_data);
            end else begin
              if (is_write) begin
                case (addr)
                  ADDR_START: spi_start_aq <= rx_byte[0];
                  ADDR_DEBUG: spi_debug    <= rx_byte[0];
                  ADDR_RESET: spi_reset    <= rx_byte[0];
                  default:    ;
                endcase
              end else if (addr == ADDR_DATA_LSB) begin
                spi_buffer_read_complete <= 1'b1;
              end
              addr      <= data_addr_next;
              shift_out <= is_write ? 8'h00
                           : read_mux(data_addr_next, spi_status, antenna_data);
            end
          end
        end else if (sck_fall) begin
          if (bit_cnt == 3'd0) begin
            MISO <= shift_out[7];
          end else begin
            shift_out <= {shift_out[6:0], 1'b0};
            MISO      <= shift_out[6];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tart_spi_regs.sv
// Directed self-checking bench for tart_spi_regs: register writes, sample reads, abort and reset.
module tb_tart_spi_regs;

  logic        fpga_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        SCK      = 1'b0;
  logic        MOSI     = 1'b0;
  logic        SSEL     = 1'b1;
  logic        MISO;
  logic [23:0] antenna_data = 24'h0;
  logic [7:0]  spi_status   = 8'h00;
  logic        spi_buffer_read_complete;
  logic        spi_reset;
  logic        spi_start_aq;
  logic        spi_debug;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   brc_cnt = 0;
  int   rst_cnt = 0;
  logic aq_at4  = 1'b0;

  logic [7:0]  rc;
  logic [23:0] rd;

  tart_spi_regs dut (
    .fpga_clk                 (fpga_clk),
    .rst_n                    (rst_n),
    .SCK                      (SCK),
    .MOSI                     (MOSI),
    .SSEL                     (SSEL),
    .MISO                     (MISO),
    .antenna_data             (antenna_data),
    .spi_status               (spi_status),
    .spi_buffer_read_complete (spi_buffer_read_complete),
    .spi_reset                (spi_reset),
    .spi_start_aq             (spi_start_aq),
    .spi_debug                (spi_debug)
  );

  always #5 fpga_clk = ~fpga_clk;

  // Count high cycles of each pulse output so width and multiplicity can be checked together.
  always @(negedge fpga_clk) begin
    if (spi_buffer_read_complete) brc_cnt++;
    if (spi_reset) rst_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge fpga_clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      wait_clks(8);
      SCK = 1'b1;
      rx = {rx[6:0], MISO};
      wait_clks(4);
      aq_at4 = spi_start_aq;
      wait_clks(4);
      SCK = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] wdata, input int ndata,
                               output logic [7:0] rx_cmd, output logic [23:0] rx_data);
    logic [7:0] b;
    brc_cnt = 0;
    rst_cnt = 0;
    rx_data = 24'h0;
    SSEL = 1'b0;
    wait_clks(8);
    spi_bits(cmd, 8, rx_cmd);
    wait_clks(16);
    for (int k = 0; k < ndata; k++) begin
      spi_bits(wdata, 8, b);
      rx_data = {rx_data[15:0], b};
      wait_clks(16);
    end
    SSEL = 1'b1;
    wait_clks(16);
  endtask

  initial begin
    wait_clks(3);
    checkOutput("rst_miso", {31'd0, MISO}, 32'd0);
    checkOutput("rst_aq", {31'd0, spi_start_aq}, 32'd0);
    checkOutput("rst_dbg", {31'd0, spi_debug}, 32'd0);
    checkOutput("rst_reset", {31'd0, spi_reset}, 32'd0);
    checkOutput("rst_brc", {31'd0, spi_buffer_read_complete}, 32'd0);
    rst_n = 1'b1;
    wait_clks(4);

    spi_status = 8'hA5;
    applyStimulus(8'h00, 8'h00, 1, rc, rd);
    checkOutput("status_cmd", {24'd0, rc}, 32'hA5);
    checkOutput("status_data", {24'd0, rd[7:0]}, 32'hA5);

    applyStimulus(8'h81, 8'h01, 1, rc, rd);
    checkOutput("aq_latency", {31'd0, aq_at4}, 32'd1);
    checkOutput("aq_set", {31'd0, spi_start_aq}, 32'd1);
    checkOutput("dbg_still0", {31'd0, spi_debug}, 32'd0);

    applyStimulus(8'h85, 8'h01, 1, rc, rd);
    checkOutput("dbg_set", {31'd0, spi_debug}, 32'd1);

    applyStimulus(8'h8F, 8'h01, 1, rc, rd);
    checkOutput("reset_pulse_cycles", rst_cnt, 32'd1);
    checkOutput("reset_low_after", {31'd0, spi_reset}, 32'd0);

    applyStimulus(8'h8F, 8'h00, 1, rc, rd);
    checkOutput("reset_d0_zero", rst_cnt, 32'd0);

    applyStimulus(8'h87, 8'h00, 1, rc, rd);
    checkOutput("ignored_aq", {31'd0, spi_start_aq}, 32'd1);
    checkOutput("ignored_dbg", {31'd0, spi_debug}, 32'd1);

    antenna_data = 24'h123456;
    applyStimulus(8'h02, 8'h00, 1, rc, rd);
    checkOutput("read_msb", {24'd0, rd[7:0]}, 32'h12);
    checkOutput("read_msb_nopulse", brc_cnt, 32'd0);
    applyStimulus(8'h03, 8'h00, 1, rc, rd);
    checkOutput("read_mid", {24'd0, rd[7:0]}, 32'h34);
    applyStimulus(8'h04, 8'h00, 1, rc, rd);
    checkOutput("read_lsb", {24'd0, rd[7:0]}, 32'h56);
    checkOutput("read_lsb_pulse", brc_cnt, 32'd1);
    applyStimulus(8'h04, 8'h00, 2, rc, rd);
    checkOutput("read_lsb_x2", {16'd0, rd[15:0]}, 32'h5656);
    checkOutput("read_lsb_x2_pulse", brc_cnt, 32'd2);
    applyStimulus(8'h06, 8'h00, 1, rc, rd);
    checkOutput("read_unmapped", {24'd0, rd[7:0]}, 32'h00);

    // Abort a write to start_aq after half of its data byte.
    spi_status = 8'h3C;
    SSEL = 1'b0;
    wait_clks(8);
    spi_bits(8'h81, 8, rc);
    wait_clks(16);
    spi_bits(8'h00, 4, rc);
    wait_clks(8);
    SSEL = 1'b1;
    wait_clks(16);
    checkOutput("abort_aq_kept", {31'd0, spi_start_aq}, 32'd1);
    applyStimulus(8'h00, 8'h00, 1, rc, rd);
    checkOutput("abort_next_cmd", {24'd0, rc}, 32'h3C);
    checkOutput("abort_next_data", {24'd0, rd[7:0]}, 32'h3C);

    antenna_data = 24'hABCDEF;
    applyStimulus(8'h02, 8'h00, 3, rc, rd);
`ifdef SPI_REGS_BURST_EN
    checkOutput("burst_data", {8'd0, rd}, 32'hABCDEF);
    checkOutput("burst_pulse", brc_cnt, 32'd1);
`else
    checkOutput("repeat_data", {8'd0, rd}, 32'hABABAB);
    checkOutput("repeat_pulse", brc_cnt, 32'd0);
`endif

    // Reset in the middle of shifting out an all-ones sample byte.
    antenna_data = 24'hFFFFFF;
    SSEL = 1'b0;
    wait_clks(8);
    spi_bits(8'h02, 8, rc);
    wait_clks(16);
    spi_bits(8'h00, 3, rc);
    wait_clks(6);
    checkOutput("miso_before_rst", {31'd0, MISO}, 32'd1);
    rst_n = 1'b0;
    wait_clks(2);
    checkOutput("midrst_miso", {31'd0, MISO}, 32'd0);
    checkOutput("midrst_aq", {31'd0, spi_start_aq}, 32'd0);
    checkOutput("midrst_dbg", {31'd0, spi_debug}, 32'd0);
    checkOutput("midrst_reset", {31'd0, spi_reset}, 32'd0);
    checkOutput("midrst_brc", {31'd0, spi_buffer_read_complete}, 32'd0);
    SSEL = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(8);

    spi_status = 8'h5A;
    applyStimulus(8'h00, 8'h00, 1, rc, rd);
    checkOutput("postrst_cmd", {24'd0, rc}, 32'h5A);
    checkOutput("postrst_data", {24'd0, rd[7:0]}, 32'h5A);
    applyStimulus(8'h85, 8'h01, 1, rc, rd);
    checkOutput("postrst_dbg", {31'd0, spi_debug}, 32'd1);
    checkOutput("postrst_aq", {31'd0, spi_start_aq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
